// File: rtl/lc3_ctrl_pkg.sv
// Shared definitions for the LC-3 pipeline controller: opcode constants,
// data-memory step encoding, main sequencer states and opcode classing.
package lc3_ctrl_pkg;

  // Opcodes, ir[15:12]
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  // Data-memory access step presented on mem_state
  localparam logic [1:0] MEM_READ  = 2'd0;
  localparam logic [1:0] MEM_IND   = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;
  localparam logic [1:0] MEM_IDLE  = 2'd3;

  // Main sequencer states
  typedef enum logic [1:0] {
    ST_RAMP = 2'd0,
    ST_RUN  = 2'd1,
    ST_MEM  = 2'd2,
    ST_CTRL = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    CLS_ALU   = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2,
    CLS_CTRL  = 2'd3
  } op_class_e;

  // Unlisted opcodes (TRAP, JSR, RTI, reserved) flow through like ALU ops
  function automatic op_class_e op_class(input logic [3:0] op);
    op_class_e cls;
    case (op)
      OP_ADD, OP_AND, OP_NOT, OP_LEA: cls = CLS_ALU;
      OP_LD,  OP_LDR, OP_LDI:         cls = CLS_LOAD;
      OP_ST,  OP_STR, OP_STI:         cls = CLS_STORE;
      OP_BR,  OP_JMP:                 cls = CLS_CTRL;
      default:                        cls = CLS_ALU;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/lc3_mem_fsm.sv
// Data-memory step sequencer: walks the read / indirect / write steps of one
// load or store and flags the edge on which the final step completes.
module lc3_mem_fsm
  import lc3_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic       complete_data,
  output logic [1:0] mem_state,
  output logic       done
);

  logic      store_q;
  op_class_e cls;

  assign cls = op_class(opcode);

  // The indirect step always precedes a plain read or write, so the final
  // step is recognisable from mem_state alone.
  assign done = complete_data && ((mem_state == MEM_READ) || (mem_state == MEM_WRITE));

  // Step register: launch on start, advance one step per completed access
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_state <= MEM_IDLE;
      store_q   <= 1'b0;
    end else if (mem_state == MEM_IDLE) begin
      if (start) begin
        case (cls)
          CLS_LOAD: begin
            store_q   <= 1'b0;
            mem_state <= (opcode == OP_LDI) ? MEM_IND : MEM_READ;
          end
          CLS_STORE: begin
            store_q   <= 1'b1;
            mem_state <= (opcode == OP_STI) ? MEM_IND : MEM_WRITE;
          end
          default: mem_state <= MEM_IDLE;
        endcase
      end
    end else if (complete_data) begin
      if (mem_state == MEM_IND) begin
        mem_state <= store_q ? MEM_WRITE : MEM_READ;
      end else begin
        mem_state <= MEM_IDLE;
      end
    end
  end

endmodule

// File: rtl/lc3_controller.sv
// LC-3 five-stage pipeline controller: ramps the stage enables up after reset
// or a control transfer, stalls the pipe for data-memory accesses and drains
// it for branches/jumps. All outputs are registered; the fetch-side enables
// are additionally masked while instruction memory has not responded.
module lc3_controller
  import lc3_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] ir_dec,
  input  logic [15:0] ir_exec,
  input  logic [2:0]  psr,
  output logic        enable_fetch,
  output logic        enable_updatePC,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic [1:0]  mem_state
);

  // Bit positions inside en_q = {fetch, updatePC, decode, execute, writeback}
  localparam int EN_DEC = 2;
  localparam int EN_EXE = 1;

  ctrl_state_e state_q;
  logic [1:0]  cnt_q;
  logic [4:0]  en_q;
  logic        br_q;

  logic        hold;
  logic        mem_start;
  logic        mem_done;
  logic        ctrl_in_dec;
  logic        br_cond;
  op_class_e   exec_cls;
  op_class_e   dec_cls;
  logic        unused_ir;

  // A missing instruction word freezes the whole controller, including the
  // data-memory sequencer, so no step is lost while the pipe is stalled.
  assign hold        = !complete_instr;
  assign exec_cls    = op_class(ir_exec[15:12]);
  assign dec_cls     = op_class(ir_dec[15:12]);
  assign ctrl_in_dec = (dec_cls == CLS_CTRL);
  assign mem_start   = (state_q == ST_RUN) && !hold && en_q[EN_EXE] &&
                       ((exec_cls == CLS_LOAD) || (exec_cls == CLS_STORE));
  assign br_cond     = (ir_exec[15:12] == OP_JMP) || (|(ir_exec[11:9] & psr));
  assign unused_ir   = ^{ir_dec[11:0], ir_exec[8:0]};

  lc3_mem_fsm u_mem_fsm (
    .clock         (clock),
    .reset         (reset),
    .start         (mem_start),
    .opcode        (ir_exec[15:12]),
    .complete_data (complete_data & complete_instr),
    .mem_state     (mem_state),
    .done          (mem_done)
  );

  // Main sequencer: ramp-up, steady run, memory stall and control drain
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RAMP;
      cnt_q   <= 2'd0;
      en_q    <= 5'b00000;
      br_q    <= 1'b0;
    end else if (!hold) begin
      case (state_q)
        ST_RAMP: begin
          // Stages come on one per edge, fetch and PC update together first
          en_q  <= {2'b11, cnt_q != 2'd0, cnt_q[1], cnt_q == 2'd3};
          br_q  <= 1'b0;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Memory op in execute wins over a control op in decode; the
          // control op is seen again once the pipe resumes.
          if (mem_start) begin
            state_q <= ST_MEM;
            cnt_q   <= 2'd0;
            en_q    <= 5'b00000;
          end else if (en_q[EN_DEC] && ctrl_in_dec) begin
            state_q <= ST_CTRL;
            cnt_q   <= 2'd0;
            en_q    <= 5'b00100;
          end else begin
            en_q    <= 5'b11111;
          end
        end
        ST_MEM: begin
          // cnt_q 0: waiting on the access; 1: writeback slot, then resume
          if (cnt_q == 2'd0) begin
            if (mem_done) begin
              en_q  <= {4'b0000, mem_state == MEM_READ};
              cnt_q <= 2'd1;
            end
          end else begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
            en_q    <= 5'b11111;
          end
        end
        ST_CTRL: begin
          // C0 decode, C1 execute, C2 redirect PC, then restart the ramp
          case (cnt_q)
            2'd0: begin
              en_q  <= 5'b00010;
              cnt_q <= 2'd1;
            end
            2'd1: begin
              en_q  <= 5'b01000;
              br_q  <= br_cond;
              cnt_q <= 2'd2;
            end
            default: begin
              state_q <= ST_RAMP;
              cnt_q   <= 2'd0;
              en_q    <= 5'b00000;
              br_q    <= 1'b0;
            end
          endcase
        end
        default: begin
          state_q <= ST_RAMP;
          cnt_q   <= 2'd0;
          en_q    <= 5'b00000;
          br_q    <= 1'b0;
        end
      endcase
    end
  end

  assign enable_fetch     = en_q[4] & complete_instr;
  assign enable_updatePC  = en_q[3] & complete_instr;
  assign enable_decode    = en_q[2] & complete_instr;
  assign enable_execute   = en_q[1];
  assign enable_writeback = en_q[0];
  assign br_taken         = br_q;

endmodule

// File: tb/tb_lc3_controller.sv
// Testbench for lc3_controller: directed vector table, hand-written corner
// sequences and a randomized run against a script-queue reference model.
module tb_lc3_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] ir_dec;
  logic [15:0] ir_exec;
  logic [2:0]  psr;
  logic        enable_fetch, enable_updatePC, enable_decode;
  logic        enable_execute, enable_writeback, br_taken;
  logic [1:0]  mem_state;

  int errors = 0;
  int checks = 0;
  bit model_on = 1'b0;

  localparam logic [15:0] A = 16'h1234;  // plain ALU filler

  always #5 clock = ~clock;

  lc3_controller dut (
    .clock            (clock),
    .reset            (reset),
    .complete_instr   (complete_instr),
    .complete_data    (complete_data),
    .ir_dec           (ir_dec),
    .ir_exec          (ir_exec),
    .psr              (psr),
    .enable_fetch     (enable_fetch),
    .enable_updatePC  (enable_updatePC),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .br_taken         (br_taken),
    .mem_state        (mem_state)
  );

  // Reference model: each operation expands into a script of expected output
  // records; gate=1 means the record holds until an edge with complete_data.
  typedef struct packed {
    logic [4:0] en;   // {fetch, updatePC, decode, execute, writeback}
    logic [1:0] ms;
    logic       br;
    logic       gate;
    logic       is_br;
  } rec_t;

  rec_t cur;
  rec_t script[$];

  function automatic rec_t mk(input logic [4:0] en, input logic [1:0] ms,
                              input logic gate, input logic is_br);
    rec_t r;
    r.en = en; r.ms = ms; r.br = 1'b0; r.gate = gate; r.is_br = is_br;
    return r;
  endfunction

  function automatic void push_ramp();
    script.push_back(mk(5'b11000, 2'd3, 1'b0, 1'b0));
    script.push_back(mk(5'b11100, 2'd3, 1'b0, 1'b0));
    script.push_back(mk(5'b11110, 2'd3, 1'b0, 1'b0));
    script.push_back(mk(5'b11111, 2'd3, 1'b0, 1'b0));
  endfunction

  function automatic void model_edge();
    logic [3:0] xop;
    logic [3:0] dop;
    int         steps[$];
    xop = ir_exec[15:12];
    dop = ir_dec[15:12];
    if (reset) begin
      cur = mk(5'b00000, 2'd3, 1'b0, 1'b0);
      script.delete();
      push_ramp();
      return;
    end
    if (!complete_instr) return;
    if (cur.gate && !complete_data) return;
    if (script.size() == 0) begin
      case (xop)
        4'h2, 4'h6: steps = '{0};
        4'hA:       steps = '{1, 0};
        4'h3, 4'h7: steps = '{2};
        4'hB:       steps = '{1, 2};
        default:    steps = '{};
      endcase
      if (cur.en[1] && steps.size() > 0) begin
        foreach (steps[k]) script.push_back(mk(5'b00000, 2'(steps[k]), 1'b1, 1'b0));
        script.push_back(mk((xop == 4'h2 || xop == 4'h6 || xop == 4'hA) ? 5'b00001 : 5'b00000,
                            2'd3, 1'b0, 1'b0));
        script.push_back(mk(5'b11111, 2'd3, 1'b0, 1'b0));
      end else if (cur.en[2] && (dop == 4'h0 || dop == 4'hC)) begin
        script.push_back(mk(5'b00100, 2'd3, 1'b0, 1'b0));
        script.push_back(mk(5'b00010, 2'd3, 1'b0, 1'b0));
        script.push_back(mk(5'b01000, 2'd3, 1'b0, 1'b1));
        script.push_back(mk(5'b00000, 2'd3, 1'b0, 1'b0));
        push_ramp();
      end
    end
    if (script.size() != 0) begin
      cur = script.pop_front();
      if (cur.is_br) cur.br = (xop == 4'hC) || (|(ir_exec[11:9] & psr));
    end
  endfunction

  task automatic drive(input logic r, input logic ci, input logic cd,
                       input logic [15:0] d, input logic [15:0] e, input logic [2:0] p);
    reset = r; complete_instr = ci; complete_data = cd;
    ir_dec = d; ir_exec = e; psr = p;
    #1;
  endtask

  task automatic check_out(input string name, input logic [4:0] en,
                           input logic [1:0] ms, input logic br);
    logic [4:0] got_en;
    got_en = {enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback};
    checks++;
    if (got_en !== en || mem_state !== ms || br_taken !== br) begin
      errors++;
      $display("FAIL %s: got en=%b mem_state=%0d br=%b, want en=%b mem_state=%0d br=%b",
               name, got_en, mem_state, br_taken, en, ms, br);
    end
  endtask

  task automatic tick();
    if (model_on) model_edge();
    @(posedge clock);
    @(negedge clock);
  endtask

  typedef struct packed {
    logic        chk;
    logic        rst, ci, cd;
    logic [15:0] d, e;
    logic [2:0]  p;
    logic [4:0]  en;
    logic [1:0]  ms;
    logic        br;
  } vec_t;

  function automatic vec_t v(input logic chk, input logic rst, input logic ci, input logic cd,
                             input logic [15:0] d, input logic [15:0] e, input logic [2:0] p,
                             input logic [4:0] en, input logic [1:0] ms, input logic br);
    vec_t x;
    x.chk = chk; x.rst = rst; x.ci = ci; x.cd = cd; x.d = d; x.e = e; x.p = p;
    x.en = en; x.ms = ms; x.br = br;
    return x;
  endfunction

  vec_t tbl[$];
  logic [4:0] ramp_pat [4] = '{5'b11000, 5'b11100, 5'b11110, 5'b11111};

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before timeout");
    $fatal(1);
  end

  initial begin
    // reset and ramp
    tbl.push_back(v(0,1,1,0, A, A, 3'b000, 5'b00000, 2'd3, 0));
    tbl.push_back(v(1,1,1,0, A, A, 3'b000, 5'b00000, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b000, 5'b00000, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b000, 5'b11000, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b000, 5'b11100, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b000, 5'b11110, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b000, 5'b11111, 2'd3, 0));
    // LD, data completes on the second wait cycle
    tbl.push_back(v(1,0,1,0, A, 16'h2ABC, 3'b000, 5'b11111, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b000, 5'b00000, 2'd0, 0));
    tbl.push_back(v(1,0,1,1, A, A, 3'b000, 5'b00000, 2'd0, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b000, 5'b00001, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b000, 5'b11111, 2'd3, 0));
    // STI: indirect then write, no writeback
    tbl.push_back(v(1,0,1,0, A, 16'hB123, 3'b000, 5'b11111, 2'd3, 0));
    tbl.push_back(v(1,0,1,1, A, A, 3'b000, 5'b00000, 2'd1, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b000, 5'b00000, 2'd2, 0));
    tbl.push_back(v(1,0,1,1, A, A, 3'b000, 5'b00000, 2'd2, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b000, 5'b00000, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b000, 5'b11111, 2'd3, 0));
    // BRnp with Z set: not taken, ramp restarts
    tbl.push_back(v(1,0,1,0, 16'h0A00, A, 3'b010, 5'b11111, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, 16'h0A00, 3'b010, 5'b00100, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, 16'h0A00, 3'b010, 5'b00010, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, 16'h0A00, 3'b010, 5'b01000, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b010, 5'b00000, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b010, 5'b11000, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b010, 5'b11100, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b010, 5'b11110, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b010, 5'b11111, 2'd3, 0));
    // BRnp with N set: taken
    tbl.push_back(v(1,0,1,0, 16'h0A00, A, 3'b100, 5'b11111, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, 16'h0A00, 3'b100, 5'b00100, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, 16'h0A00, 3'b100, 5'b00010, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, 16'h0A00, 3'b100, 5'b01000, 2'd3, 1));
    tbl.push_back(v(1,0,1,0, A, A, 3'b100, 5'b00000, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b100, 5'b11000, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b100, 5'b11100, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b100, 5'b11110, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b100, 5'b11111, 2'd3, 0));
    // instruction memory stall in RUN masks the fetch-side enables at once
    tbl.push_back(v(1,0,0,0, A, A, 3'b000, 5'b00011, 2'd3, 0));
    tbl.push_back(v(1,0,1,0, A, A, 3'b000, 5'b11111, 2'd3, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].ci, tbl[i].cd, tbl[i].d, tbl[i].e, tbl[i].p);
      if (tbl[i].chk) check_out($sformatf("vec%0d", i), tbl[i].en, tbl[i].ms, tbl[i].br);
      tick();
    end

    // LDR in execute with JMP in decode: memory first, then the jump
    drive(0,1,0, 16'hC000, 16'h6000, 3'b000); check_out("pri_run",  5'b11111, 2'd3, 0); tick();
    drive(0,1,1, 16'hC000, A, 3'b000);        check_out("pri_mem",  5'b00000, 2'd0, 0); tick();
    drive(0,1,0, 16'hC000, A, 3'b000);        check_out("pri_wb",   5'b00001, 2'd3, 0); tick();
    drive(0,1,0, 16'hC000, A, 3'b000);        check_out("pri_run2", 5'b11111, 2'd3, 0); tick();
    drive(0,1,0, A, 16'hC000, 3'b000);        check_out("jmp_c0",   5'b00100, 2'd3, 0); tick();
    check_out("jmp_c1", 5'b00010, 2'd3, 0); tick();
    check_out("jmp_c2", 5'b01000, 2'd3, 1); tick();
    drive(0,1,0, A, A, 3'b000);               check_out("jmp_ramp0", 5'b00000, 2'd3, 0); tick();
    for (int k = 0; k < 4; k++) begin
      check_out($sformatf("jmp_ramp%0d", k + 1), ramp_pat[k], 2'd3, 0); tick();
    end

    // BR with no condition bits: never taken, full drain still happens
    drive(0,1,0, 16'h01FF, A, 3'b111);        check_out("brz_run", 5'b11111, 2'd3, 0); tick();
    drive(0,1,0, A, 16'h01FF, 3'b111);        check_out("brz_c0",  5'b00100, 2'd3, 0); tick();
    check_out("brz_c1", 5'b00010, 2'd3, 0); tick();
    check_out("brz_c2", 5'b01000, 2'd3, 0); tick();
    drive(0,1,0, A, A, 3'b111);               check_out("brz_ramp0", 5'b00000, 2'd3, 0); tick();
    for (int k = 0; k < 4; k++) begin
      check_out($sformatf("brz_ramp%0d", k + 1), ramp_pat[k], 2'd3, 0); tick();
    end

    // Reset during the indirect step of LDI abandons the access
    drive(0,1,0, A, 16'hA000, 3'b000);        check_out("ldi_run",  5'b11111, 2'd3, 0); tick();
    drive(1,1,1, A, A, 3'b000);               check_out("ldi_ind",  5'b00000, 2'd1, 0); tick();
    drive(0,1,1, A, A, 3'b000);               check_out("rst_mem",  5'b00000, 2'd3, 0); tick();
    drive(0,1,0, A, A, 3'b000);               check_out("rst_ramp1", 5'b11000, 2'd3, 0); tick();

    // Randomized run against the model
    drive(1,1,0, A, A, 3'b000);
    model_on = 1'b1;
    tick();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
            16'($urandom), 16'($urandom), 3'($urandom));
      check_out("rand", {cur.en[4:2] & {3{complete_instr}}, cur.en[1:0]}, cur.ms, cur.br);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3_controller.md
LC3_CONTROLLER -- requirements
Module: lc3_controller

Interface
REQ-001 clock  in  1  single clock; all state updates on the rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 complete_instr  in  1  instruction memory returned valid dout this cycle.
REQ-004 complete_data  in  1  data memory access finished this cycle.
REQ-005 ir_dec  in  16  instruction currently presented to decode (dout).
REQ-006 ir_exec  in  16  instruction currently held in execute.
REQ-007 psr  in  3  current N,Z,P condition codes.
REQ-008 enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback  out  1 each  stage enables; enable_decode drives enable_decode_s.
REQ-009 br_taken  out  1  redirect PC to the branch/jump target.
REQ-010 mem_state  out  2  0=read, 1=indirect read, 2=write, 3=idle.

Function
REQ-011 Opcode classes (ir[15:12]) SHALL be:
- ALU: 0001, 0101, 1001, 1110.
- Load: 0010, 0110, 1010.
- Store: 0011, 0111, 1011.
- Control: 0000 (BR), 1100 (JMP).
- Any other opcode SHALL be treated as ALU.
REQ-012 The main FSM SHALL have states RAMP, RUN, MEM and CTRL; all outputs SHALL be registered.
REQ-013 RAMP SHALL assert enables cumulatively, then enter RUN:
- edge 1: enable_fetch, enable_updatePC;
- edge 2: adds enable_decode;
- edge 3: adds enable_execute;
- edge 4: adds enable_writeback.
REQ-014 In RUN, all five enables SHALL be 1 and mem_state SHALL be 3.
REQ-015 While complete_instr=0, enable_fetch, enable_updatePC and enable_decode SHALL be forced to 0 combinationally; the FSM SHALL hold its state.
REQ-016 In RUN, when enable_execute=1 and ir_exec is Load or Store, the next edge SHALL enter MEM with all five enables 0.
REQ-017 The mem_state sequence SHALL be:
- LD/LDR: 0.
- LDI: 1 then 0.
- ST/STR: 2.
- STI: 1 then 2.
- Each step SHALL advance only on an edge with complete_data=1.
REQ-018 When the final MEM step completes:
- mem_state SHALL return to 3;
- for loads, enable_writeback=1 for exactly one cycle;
- the FSM SHALL then return to RUN with all enables restored on the following edge.
REQ-019 In RUN, when enable_decode=1 and ir_dec is Control, the next edge SHALL enter CTRL, which runs three cycles:
- C0: fetch/updatePC=0, decode=1;
- C1: decode=0, execute=1;
- C2: execute=0, enable_updatePC=1, br_taken valid.
REQ-020 br_taken SHALL be 1 only in C2, with value:
- BR: |(ir_exec[11:9] & psr);
- JMP: 1.
REQ-021 After C2, the FSM SHALL re-enter RAMP from edge 1.
REQ-022 If Load/Store-in-execute and Control-in-decode coincide, MEM SHALL take priority; Control SHALL be evaluated on return to RUN.
REQ-023 BR with ir[11:9]=000 SHALL give br_taken=0 but SHALL still run the full CTRL sequence.

Reset
REQ-024 While reset=1 at an edge:
- all enables and br_taken SHALL be 0;
- mem_state SHALL be 3;
- the FSM SHALL be in RAMP with its counter at 0.
REQ-025 Reset asserted mid-MEM or mid-CTRL SHALL abandon the operation with the REQ-024 values at that edge; no partial writeback SHALL occur.

Structure
REQ-026 Package lc3_ctrl_pkg SHALL hold the opcode constants, the mem_state encoding and the FSM state enum.
REQ-027 The memory sequencing SHALL live in sub-module lc3_mem_fsm, which takes start, opcode and complete_data and returns mem_state and done.
REQ-028 The RTL SHALL need no counter wider than 2 bits.

Verification
REQ-029 Reset pulse, then idle ALU stream: enables rise cumulatively on edges 1-4, then all 1; mem_state=3 throughout.
REQ-030 ir_exec=16'h2xxx (LD), complete_data after 2 cycles: mem_state 3→0→3, enables 0 for 3 cycles, enable_writeback pulses once, then RUN.
REQ-031 ir_exec=16'hBxxx (STI): mem_state 1→2→3, no writeback pulse.
REQ-032 ir_dec=16'h0A00 (BRnp) with psr=3'b010: br_taken=0 in C2; rerun with psr=3'b100: br_taken=1; RAMP restarts after C2.
REQ-033 Simultaneous LDR in execute and JMP in decode: MEM first, then CTRL with br_taken=1.
REQ-034 Reset asserted during mem_state=1: next edge all outputs 0 and mem_state=3; complete_instr=0 in RUN: fetch/updatePC/decode 0 the same cycle.
